// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, fixed 33-cycle start-to-done latency.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_next;
  logic [2:0]          op;
  logic [4:0]          rd_cap, cnt;
  logic                neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0]     opa, opb, rem, rem_next, diff;
  logic [2*XLEN-1:0]   acc, acc_next, prod;
  logic [XLEN:0]       mul_sum, rem_shift;
  logic [XLEN-1:0]     quo_f, rem_f, final_val, mag_a, mag_b;
  logic                sgn_a, sgn_b, in_neg_a, in_neg_b, ge;

  // Operand signedness and magnitudes for the request being presented.
  always_comb begin
    sgn_a    = funct3[2] ? ~funct3[0] : (funct3 != 3'b011);
    sgn_b    = funct3[2] ? ~funct3[0] : ~funct3[1];
    in_neg_a = sgn_a & rs1_val[XLEN-1];
    in_neg_b = sgn_b & rs2_val[XLEN-1];
    mag_a    = in_neg_a ? -rs1_val : rs1_val;
    mag_b    = in_neg_b ? -rs2_val : rs2_val;
  end

  // One iteration; acc holds {partial product, multiplier} or {0, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opa} : '0);
    rem_shift = {rem, acc[XLEN-1]};
    diff      = rem_shift[XLEN-1:0] - opb;
    ge        = rem_shift >= {1'b0, opb};
    acc_next  = {mul_sum, acc[XLEN-1:1]};
    rem_next  = rem;
    if (op[2]) begin
      acc_next = {{XLEN{1'b0}}, acc[XLEN-2:0], ge};
      rem_next = ge ? diff : rem_shift[XLEN-1:0];
    end
    prod  = (neg_a ^ neg_b) ? -acc_next : acc_next;
    quo_f = (neg_a ^ neg_b) ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem_f = neg_a ? -rem_next : rem_next;
    case (op)
      3'b000:                 final_val = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_val = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:
        final_val = div_zero ? '1 : (div_ovf ? {1'b1, {(XLEN-1){1'b0}}} : quo_f);
      default:
        final_val = div_zero ? (neg_a ? -opa : opa) : (div_ovf ? '0 : rem_f);
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (cnt == 5'(XLEN-1)) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      result   <= '0;
      rd_out   <= '0;
      op       <= '0;
      rd_cap   <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      rem      <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) begin
          op       <= funct3;
          rd_cap   <= rd_in;
          neg_a    <= in_neg_a;
          neg_b    <= in_neg_b;
          opa      <= mag_a;
          opb      <= mag_b;
          acc      <= {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
          rem      <= '0;
          cnt      <= '0;
          div_zero <= (rs2_val == '0);
          div_ovf  <= funct3[2] & ~funct3[0] & (rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                      & (rs2_val == '1);
        end
        BUSY: begin
          acc <= acc_next;
          rem <= rem_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(XLEN-1)) begin
            result <= final_val;
            rd_out <= rd_cap;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: arithmetic reference model, queue of expected
// write-backs with completion cycle, and an independent done monitor.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val, result;
  logic [4:0]  rd_in, rd_out;
  logic        busy, done;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int unsigned when;
  } exp_t;
  exp_t sb[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb64, ub, p;
    logic [63:0] up;
    logic ovf;
    sa   = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ub   = {32'b0, b};
    up   = {32'b0, a} * {32'b0, b};
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb64; return p[31:0]; end
      3'd1: begin p = sa * sb64; return p[63:32]; end
      3'd2: begin p = sa * ub;   return p[63:32]; end
      3'd3: return up[63:32];
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
        check("latency", cyc, e.when);
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit hold);
    int n;
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1_val = a; rs2_val = b; rd_in = rd;
    @(posedge clk); #1;
    sb.push_back('{ref_model(f, a, b), rd, cyc + 32});
    check("busy_after_start", {31'b0, busy}, 32'd1);
    if (!hold) start = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
      if (hold) begin
        if (done === 1'b1) start = 1'b0;
        else begin
          rs1_val = $urandom; rs2_val = $urandom;
          funct3 = 3'($urandom); rd_in = 5'($urandom);
        end
      end
    end
    start = 1'b0;
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy=1 expected idle within 60 cycles");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; funct3 = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   {31'b0, busy}, 32'd0);
    check("reset_done",   {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd_out", {27'b0, rd_out}, 32'd0);
    @(negedge clk) reset = 1'b0;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 1'b0);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b0);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b0);
    issue(3'd5, 32'd100, 32'd7, 5'd6, 1'b0);
    issue(3'd7, 32'd100, 32'd7, 5'd7, 1'b0);
    issue(3'd5, 32'd5, 32'd0, 5'd8, 1'b0);
    issue(3'd6, 32'd5, 32'd0, 5'd10, 1'b0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
    issue(3'd0, 32'd5, 32'd6, 5'd0, 1'b0);
    issue(3'd0, 32'h1234_5678, 32'h0000_0101, 5'd13, 1'b1);

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 15); end
        3: b = 32'($urandom_range(0, 9)) - 32'd5;
        default: ;
      endcase
      issue(f, a, b, 5'($urandom), 1'b0);
    end

    // Abort a DIV mid-flight; the prior op left a nonzero result behind.
    issue(3'd0, 32'd11, 32'd13, 5'd14, 1'b0);
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd15;
    @(negedge clk) start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy",   {31'b0, busy}, 32'd0);
    check("abort_done",   {31'b0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_rd_out", {27'b0, rd_out}, 32'd0);
    @(negedge clk) reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd3, 32'd4, 5'd16, 1'b0);

    @(negedge clk);
    reset = 1'b1; start = 1'b1; funct3 = 3'd0; rs1_val = 32'd2; rs2_val = 32'd2;
    @(posedge clk); #1;
    check("reset_beats_start", {31'b0, busy}, 32'd0);
    @(negedge clk) begin reset = 1'b0; start = 1'b0; end
    repeat (40) @(negedge clk);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit for the single-cycle core. It consumes the two register-file read operands and returns a 32-bit write-back value plus destination register index. The core holds the PC and suppresses the register-file write while `busy` is high, then writes `result` to `rd_out` in the cycle `done` is high. One operation is in flight at a time, with a fixed 33-cycle latency.

## Interface
- `XLEN`, 32: operand/result width. Only 32 is supported; the iteration count equals `XLEN`.
- `clk` in 1: clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `funct3` in 3: operation select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_val` in XLEN: dividend or multiplicand, from register-file read port 1.
- `rs2_val` in XLEN: divisor or multiplier, from register-file read port 2.
- `rd_in` in 5: destination register index, captured with the operands.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: single-cycle pulse meaning `result` and `rd_out` are valid.
- `result` out XLEN: write-back value; holds until the next accepted start.
- `rd_out` out 5: captured `rd_in`; holds like `result`.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
  - IDLE to BUSY: on `start`=1. In that cycle the block captures `funct3` and `rd_in`, the operand magnitudes, and the result sign. It clears the 5-bit iteration counter.
  - BUSY to BUSY: one iteration per cycle, counter increments.
  - BUSY to DONE: on the edge that completes iteration 31.
  - DONE to IDLE: unconditionally, after one cycle.
- Signedness of the operands:
  - Signed rs1 for MUL, MULH, MULHSU, DIV and REM.
  - Signed rs2 for MUL, MULH, DIV and REM.
  - Signed operands are converted to magnitudes; the sign is applied at completion.
- Multiply:
  - Shift-add over a 64-bit accumulator, one multiplier bit per cycle.
  - The final 64-bit product is negated if exactly one operand was negative.
  - MUL returns product[31:0]. MULH, MULHSU and MULHU return product[63:32].
- Divide: restoring, one quotient bit per cycle, using a 33-bit partial remainder.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
- Divide special cases still take the full latency; the forced value is loaded into `result` on entry to DONE.
  - Divisor 0: DIV and DIVU return 0xFFFFFFFF; REM and REMU return rs1 unchanged.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV returns 0x80000000, REM returns 0.
- All arithmetic is modulo 2^32 on the output; no exceptions or flags are raised.
- `start` is ignored in BUSY and DONE; operand and `funct3` changes there have no effect.
- The register index `rd_in`=0 is passed through unchanged; suppressing the x0 write is the register file's job.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0, counter 0.
- Start is sampled in cycle T (IDLE, `start`=1).
  - `busy`=1 from cycle T+1 through T+33.
  - `done`=1 and `result` valid in cycle T+33 only.
  - The block is back in IDLE at T+34.
- Earliest next start is cycle T+34, so throughput is one operation per 34 cycles.
- `result` and `rd_out` are registered. They change only on entry to DONE or on reset, and are stable from T+33 until the next completion.
- Reset asserted in any state, including mid-BUSY or during DONE:
  - Next cycle: IDLE with all outputs at their reset values.
  - The in-flight operation is discarded and no `done` is produced.
- If `start` and `reset` are both high, reset wins and the start is not accepted.

## Test plan
- MUL with 7 and 0xFFFFFFFD (−3): `done` exactly 33 cycles after start, `result`=0xFFFFFFEB, `rd_out` equals the captured `rd_in`.
- High-word products:
  - MULH 0x80000000 × 0x80000000 gives 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFF.
- Signed divide with rs1=0xFFFFFFF9 (−7) and rs2=2: DIV gives 0xFFFFFFFD and REM gives 0xFFFFFFFF. DIVU 100/7 gives 14 and REMU 100/7 gives 2.
- Special cases:
  - DIVU 5/0 gives 0xFFFFFFFF; REM 5/0 gives 5.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0.
  - All of these take the 33-cycle latency.
- Start held high during BUSY with different operands: only the first operation completes, a single `done` pulse, `result` from the first operands.
- Reset asserted 10 cycles into a DIV: next cycle `busy`=0, `done`=0, `result`=0, and no `done` is ever produced for it. A subsequent MUL 3×4 returns 12 after 33 cycles.
